// File: rtl/narnet_sequencer.sv
// narnet_sequencer: priming / closed-loop prediction job controller for the NAR-Net core,
// with a first-word fall-through output FIFO. Optional watchdog: NARNET_SEQ_TIMEOUT_EN.
module narnet_sequencer #(
  parameter int N       = 10,
  parameter int Q       = 8,
  parameter int CW      = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] prime_len,
  input  logic [CW-1:0] horizon,
  input  logic [N-1:0]  seed_x,
  input  logic [N-1:0]  s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [N-1:0]  net_x,
  output logic          net_x_ready,
  input  logic [N-1:0]  net_y,
  input  logic          net_out_ready,
  output logic [N-1:0]  m_data,
  output logic          m_last,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          busy,
  output logic          done,
  output logic          err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_STORE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // Q is the core's fixed-point format and is only carried here; this branch is never
  // elaborated for a legal configuration.
  if (Q >= N || TIMEOUT < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_cfg_invalid
  end

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] prime_q, prime_d, hor_q, hor_d;
  logic          priming_q, priming_d;
  logic [N-1:0]  x_q, x_d, fb_q, fb_d;

  logic [N:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          full, empty, push, pop, flush, last;

`ifdef NARNET_SEQ_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0] wd_q, wd_d;
  logic           err_q, err_d;
`endif

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);
  assign pop   = m_ready && !empty;
  // A full FIFO still accepts the push when the head leaves in the same cycle.
  assign push  = (state_q == S_STORE) && (!full || pop);
  assign last  = (hor_q == CW'(1));

  always_comb begin
    state_d   = state_q;
    prime_d   = prime_q;
    hor_d     = hor_q;
    priming_d = priming_q;
    x_d       = x_q;
    fb_d      = fb_q;
    flush     = 1'b0;
`ifdef NARNET_SEQ_TIMEOUT_EN
    err_d     = err_q;
    wd_d      = '0;
`endif
    case (state_q)
      S_IDLE: if (start) begin
        prime_d   = prime_len;
        hor_d     = horizon;
        priming_d = (prime_len != '0);
`ifdef NARNET_SEQ_TIMEOUT_EN
        err_d     = 1'b0;
`endif
        if (prime_len != '0) begin
          state_d = S_FETCH;
        end else if (horizon != '0) begin
          x_d     = seed_x;
          state_d = S_ISSUE;
        end else begin
          state_d = S_DONE;
        end
      end
      S_FETCH: if (s_valid) begin
        x_d     = s_data;
        prime_d = prime_q - CW'(1);
        state_d = S_ISSUE;
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
`ifdef NARNET_SEQ_TIMEOUT_EN
        wd_d = wd_q + WDW'(1);
`endif
        if (net_out_ready) begin
          fb_d = net_y;
          if (!priming_q) begin
            state_d = S_STORE;
          end else if (prime_q != '0) begin
            state_d = S_FETCH;
          end else begin
            priming_d = 1'b0;
            x_d       = net_y;
            state_d   = (hor_q != '0) ? S_ISSUE : S_DONE;
          end
        end
`ifdef NARNET_SEQ_TIMEOUT_EN
        else if (wd_q == WDW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          flush   = 1'b1;
          state_d = S_DONE;
        end
`endif
      end
      S_STORE: if (push) begin
        hor_d = hor_q - CW'(1);
        if (last) begin
          state_d = S_DONE;
        end else begin
          x_d     = fb_q;
          state_d = S_ISSUE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      prime_q   <= '0;
      hor_q     <= '0;
      priming_q <= 1'b0;
      x_q       <= '0;
      fb_q      <= '0;
    end else begin
      state_q   <= state_d;
      prime_q   <= prime_d;
      hor_q     <= hor_d;
      priming_q <= priming_d;
      x_q       <= x_d;
      fb_q      <= fb_d;
    end
  end

`ifdef NARNET_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      if (push && !pop)      cnt_q <= cnt_q + (AW+1)'(1);
      else if (!push && pop) cnt_q <= cnt_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {last, fb_q};
  end

  assign m_valid     = !empty;
  assign m_data      = m_valid ? mem_q[rd_q][N-1:0] : '0;
  assign m_last      = m_valid & mem_q[rd_q][N];
  assign s_ready     = (state_q == S_FETCH);
  assign net_x_ready = (state_q == S_ISSUE);
  assign net_x       = x_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
endmodule

// File: tb/tb_narnet_sequencer.sv
// Randomized self-checking bench for narnet_sequencer: a behavioural core, sample source and
// FIFO sink, with expected issue/prediction streams computed from the job rules.
module tb_narnet_sequencer;
  localparam int N     = 10;
  localparam int CW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] prime_len = '0, horizon = '0;
  logic [N-1:0]  seed_x = '0, s_data = '0, net_y = '0;
  logic          s_valid = 1'b0, net_out_ready = 1'b0, m_ready = 1'b0;
  logic          s_ready, net_x_ready, m_last, m_valid, busy, done, err;
  logic [N-1:0]  net_x, m_data;

  always #5 clk = ~clk;

  narnet_sequencer #(.N(N), .Q(8), .CW(CW), .DEPTH(DEPTH), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .start(start), .prime_len(prime_len), .horizon(horizon),
    .seed_x(seed_x), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .net_x(net_x), .net_x_ready(net_x_ready), .net_y(net_y), .net_out_ready(net_out_ready),
    .m_data(m_data), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .done(done), .err(err)
  );

  int n_checks = 0, n_fail = 0;
  int issue_cnt = 0, done_cnt = 0, issue_base = 0, done_base = 0;
  int mr_mode = 1;   // 0: sink stalled, 1: random pops, 2: always pop
  bit fmode = 1'b0;  // 0: core computes x+1, 1: core computes 5x+3

  logic [N-1:0] src_q[$], exp_x[$], dir_q[$];
  logic [N:0]   exp_pred[$];

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] core_f(input logic [N-1:0] x);
    return fmode ? N'(x * 5 + 3) : N'(x + 1);
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_s_ready"}, s_ready, 0);
    check_eq({tag, "_net_x"}, net_x, 0);
    check_eq({tag, "_net_x_ready"}, net_x_ready, 0);
    check_eq({tag, "_m_valid"}, m_valid, 0);
    check_eq({tag, "_m_last"}, m_last, 0);
    check_eq({tag, "_m_data"}, m_data, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_err"}, err, 0);
  endtask

  // Behavioural core: answers each x_ready pulse after a random latency; stray strobes
  // with junk data are injected whenever no answer is owed.
  initial begin : core_model
    bit have = 1'b0;
    int pend = 0;
    logic [N-1:0] px = '0;
    forever begin
      @(negedge clk);
      net_out_ready = 1'b0;
      net_y = N'($urandom);
      if (!rst) begin have = 1'b0; continue; end
      if (have) begin
        if (pend == 0) begin
          net_out_ready = 1'b1;
          net_y = core_f(px);
          have = 1'b0;
        end else pend--;
      end else if ($urandom_range(0, 7) == 0) begin
        net_out_ready = 1'b1;
      end
      if (net_x_ready) begin
        issue_cnt++;
        if (exp_x.size() == 0) check_eq("unexpected_issue", 1, 0);
        else check_eq("net_x", net_x, exp_x.pop_front());
        px = net_x;
        have = 1'b1;
        pend = $urandom_range(0, 3);
      end
    end
  end

  initial begin : sample_source
    bit consumed = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin s_valid = 1'b0; consumed = 1'b0; continue; end
      if (consumed) begin s_valid = 1'b0; consumed = 1'b0; end
      if (!s_valid) begin
        if (src_q.size() > 0 && $urandom_range(0, 2) != 0) begin
          s_data  = src_q.pop_front();
          s_valid = 1'b1;
        end else s_data = N'($urandom);
      end
      if (s_valid && s_ready) consumed = 1'b1;
    end
  end

  initial begin : sink
    logic [N:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin m_ready = 1'b0; continue; end
      case (mr_mode)
        0:       m_ready = 1'b0;
        1:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b1;
      endcase
      if (m_valid && m_ready) begin
        if (exp_pred.size() == 0) check_eq("unexpected_pop", 1, 0);
        else begin
          e = exp_pred.pop_front();
          check_eq("m_data", m_data, e[N-1:0]);
          check_eq("m_last", m_last, e[N]);
        end
      end
    end
  end

  initial begin : done_monitor
    bit prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && done) begin
        done_cnt++;
        if (prev) check_eq("done_width", 2, 1);
      end
      prev = rst && done;
    end
  end

  // Builds the expected streams, then pulses start; returns on the negedge after start.
  task automatic launch(input int p, input int h, input logic [N-1:0] seed);
    logic [N-1:0] x, y;
    x = seed;
    for (int i = 0; i < p; i++) begin
      if (dir_q.size() > 0) y = dir_q.pop_front();
      else y = N'($urandom);
      src_q.push_back(y);
      exp_x.push_back(y);
      x = core_f(y);
    end
    for (int k = 0; k < h; k++) begin
      exp_x.push_back(x);
      y = core_f(x);
      exp_pred.push_back({(k == h - 1), y});
      x = y;
    end
    @(negedge clk);
    issue_base = issue_cnt;
    done_base  = done_cnt;
    start = 1'b1; prime_len = CW'(p); horizon = CW'(h); seed_x = seed;
    @(negedge clk);
    start = 1'b0; prime_len = CW'($urandom); horizon = CW'($urandom); seed_x = N'($urandom);
    check_eq("busy_after_start", busy, 1);
  endtask

  task automatic finish_job(input int p, input int h, input bit mid_start);
    int cyc = 0;
    check_eq("done_after_start", done, (p == 0 && h == 0));
    while (cyc < 20000) begin
      if (cyc == 4) start = 1'b0;
      if (done) break;
      if (mid_start && cyc == 3 && busy) begin
        start = 1'b1; prime_len = '0; horizon = CW'(1); seed_x = N'(321);
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check_eq("done_seen", done, 1);
    @(negedge clk);
    check_eq("busy_cleared", busy, 0);
    check_eq("done_single", done, 0);
    check_eq("done_count", done_cnt - done_base, 1);
    cyc = 0;
    while ((exp_pred.size() > 0 || m_valid) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("fifo_drained", m_valid, 0);
    check_eq("preds_left", exp_pred.size(), 0);
    check_eq("issues_left", exp_x.size(), 0);
    check_eq("issue_count", issue_cnt - issue_base, p + h);
  endtask

  initial begin : main
    int cyc, p, h;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Worked example: samples 10,20,30 with y=x+1.
    fmode = 1'b0; mr_mode = 1;
    dir_q.push_back(N'(10)); dir_q.push_back(N'(20)); dir_q.push_back(N'(30));
    launch(3, 2, N'(0));
    finish_job(3, 2, 1'b1);

    launch(0, 1, N'(5));
    finish_job(0, 1, 1'b0);

    launch(0, 0, N'(9));
    finish_job(0, 0, 1'b0);

    // Back-pressure: sink stalled, horizon exceeds FIFO depth.
    fmode = 1'b1; mr_mode = 0;
    launch(0, 6, N'(77));
    repeat (60) @(negedge clk);
    check_eq("bp_issues", issue_cnt - issue_base, DEPTH + 1);
    check_eq("bp_busy", busy, 1);
    check_eq("bp_m_valid", m_valid, 1);
    check_eq("bp_head", m_data, exp_pred[0][N-1:0]);
    check_eq("bp_no_done", done_cnt - done_base, 0);
    mr_mode = 2;
    finish_job(0, 6, 1'b0);

    // Reset while the core owes an answer.
    mr_mode = 1;
    launch(2, 3, N'(200));
    cyc = 0;
    while (!net_x_ready && cyc < 200) begin @(negedge clk); cyc++; end
    check_eq("reset_pulse_seen", net_x_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    src_q.delete();
    #1;
    check_all_zero("midjob_reset");
    repeat (2) @(negedge clk);
    exp_x.delete(); exp_pred.delete(); src_q.delete();
    rst = 1'b1;
    @(negedge clk);
    check_eq("post_reset_busy", busy, 0);
    launch(1, 2, N'(3));
    finish_job(1, 2, 1'b0);

    launch(255, 2, N'(0));
    finish_job(255, 2, 1'b0);

    for (int j = 0; j < 12; j++) begin
      p = $urandom_range(0, 6);
      h = $urandom_range(0, 7);
      mr_mode = $urandom_range(1, 2);
      launch(p, h, N'($urandom));
      finish_job(p, h, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/narnet_sequencer.md
Name: narnet_sequencer

Overview:
- Sits directly upstream and downstream of the NAR-Net core. Drives the core's sample input handshake and consumes its one-cycle output strobe.
- Runs a two-phase job:
  - Priming (open loop): streams PRIME external samples into the core; the core's predictions are discarded.
  - Prediction (closed loop): feeds each core output back as the next input for HORIZON steps, queuing every prediction in an output FIFO.

Parameters:
- N, 10, sample word width (signed fixed point, shared with the core).
- Q, 8, fractional bits (pass-through only; no arithmetic on Q).
- CW, 8, width of the prime/horizon counters.
- DEPTH, 4, output FIFO entries (power of two, >=2).
- TIMEOUT, 255, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  reset, active-low, asynchronous
- start  in  1  one-cycle job start; ignored while busy=1
- prime_len  in  CW  number of external priming samples, latched on start
- horizon  in  CW  number of closed-loop predictions, latched on start
- seed_x  in  N  first closed-loop input when prime_len=0, latched on start
- s_data  in  N  external sample
- s_valid  in  1  external sample valid
- s_ready  out  1  sample accepted when s_valid&s_ready
- net_x  out  N  to core x_in
- net_x_ready  out  1  to core x_ready; single-cycle pulse
- net_y  in  N  from core y_out
- net_out_ready  in  1  from core out_ready; one-cycle strobe
- m_data  out  N  prediction from FIFO head
- m_last  out  1  head entry is the final prediction of the job
- m_valid  out  1  FIFO non-empty
- m_ready  in  1  downstream pop
- busy  out  1  job active
- done  out  1  one-cycle pulse when the job completes
- err  out  1  sticky watchdog error (optional feature only, else tied 0)

Behaviour:
- Reset (rst=0, async): state IDLE; FIFO emptied. All outputs 0: s_ready, net_x, net_x_ready, m_valid, m_last, m_data, busy, done, err. Counters cleared.

State machine:
- IDLE:
  - On start: latch prime_len, horizon, seed_x; busy<=1.
  - prime_len>0 -> FETCH.
  - prime_len=0 and horizon>0 -> ISSUE with net_x<=seed_x.
  - Both zero -> DONE.
- FETCH:
  - s_ready=1 only in this state.
  - On s_valid: net_x<=s_data, prime counter decrements, -> ISSUE.
- ISSUE:
  - net_x_ready=1 for exactly this one cycle; net_x held stable until the next ISSUE.
  - -> WAIT.
- WAIT:
  - Await net_out_ready.
  - net_y is sampled on the strobe cycle into fb_reg.
  - Priming step: if prime counter still >0 -> FETCH.
  - Last priming step: net_x<=net_y; -> ISSUE if horizon>0, else DONE.
  - Closed-loop step -> STORE.
- STORE:
  - If FIFO not full: push {net_y held in fb_reg, last = (horizon counter==1)}; horizon counter decrements.
  - After the push: counter reaches 0 -> DONE; otherwise net_x<=fb_reg and -> ISSUE.
  - If FIFO full: remain in STORE. The core is not restarted until the push succeeds (back-pressure).
- DONE:
  - done=1 for one cycle; busy<=0; -> IDLE.
  - The FIFO continues draining after DONE.

Latency:
- Start to first net_x_ready: 1 cycle after the s_valid handshake in FETCH.
- Core strobe to FIFO push: 1 cycle when the FIFO is not full.

FIFO:
- First-word fall-through; m_data/m_last valid whenever m_valid=1.
- Simultaneous push and pop when full is allowed and the count is unchanged.
- Pop when empty is ignored.

Other rules:
- No arithmetic on samples; feedback is a bit-exact copy of net_y.
- net_out_ready arriving outside WAIT is ignored.
- start while busy=1 is ignored.
- Counters are CW-bit unsigned; prime_len=2^CW-1 must work without wrap.

Optional Feature:
- Macro: NARNET_SEQ_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT and clears on entry to WAIT.
  - If it reaches TIMEOUT without net_out_ready: err<=1 (sticky until reset or next accepted start), FIFO flushed, done pulses, -> IDLE.
- Undefined: no counter; err tied 0; WAIT waits indefinitely.

Test Plan:
- Reset mid-job: assert rst=0 during WAIT -> next cycle all outputs 0, FIFO empty, IDLE; a later start runs normally.
- prime_len=3, horizon=2, core model returns y=x+1:
  - samples 10,20,30 -> exactly three net_x_ready pulses with net_x 10,20,30.
  - Then closed-loop pulses with net_x 31 and 32.
  - FIFO holds 32 then 33 with m_last=0,1; done pulses once.
- prime_len=0, seed_x=5, horizon=1 -> single net_x_ready with net_x=5; one FIFO entry 6 with m_last=1.
- DEPTH=4, horizon=6, m_ready=0 -> FIFO fills to 4, sequencer stalls in STORE with no further net_x_ready. Raise m_ready -> remaining 2 predictions complete in order.
- prime_len=0, horizon=0 -> no net_x_ready; done pulses 1 cycle after start. A start pulse during busy is ignored.
- With NARNET_SEQ_TIMEOUT_EN and TIMEOUT=20, core never strobes -> err=1 and done pulse 21 cycles after ISSUE; FIFO empty.
